// File: rtl/camera_frame_capture.sv
// camera_frame_capture: samples an OV7670 parallel bus in the system clock domain,
// assembles RGB444/RGB565 byte pairs into RGB888, decimates, and issues addressed
// pixel writes. Supports freeze/release for still capture.
module camera_frame_capture #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int DECIM       = 1,
    parameter int ADDR_W      = 19,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_fmt,
    input  logic              i_pclk,
    input  logic              i_vsync,
    input  logic              i_href,
    input  logic [7:0]        i_data,
    input  logic              i_capture,
    input  logic              i_release,
    output logic              o_wr_valid,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [23:0]       o_wr_data,
    input  logic              i_wr_ready,
    output logic              o_frame_done,
    output logic              o_frozen,
    output logic              o_overflow,
    output logic              o_err_size
);
    // Counters saturate one past the active size so over-long lines/frames still
    // register as a size error instead of wrapping.
    localparam int COL_W = $clog2(H_ACTIVE + 2);
    localparam int ROW_W = $clog2(V_ACTIVE + 2);
    localparam int DMASK = DECIM - 1;

    typedef enum logic [2:0] {IDLE, WAIT_VS, WAIT_FRAME, ACTIVE, FROZEN} state_t;

    typedef struct packed {
        logic       pclk;
        logic       vsync;
        logic       href;
        logic [7:0] data;
    } cam_t;

    cam_t [SYNC_STAGES-1:0] sync_q;
    cam_t                   cam;
    logic                   pclk_d, vsync_d, href_d;

    state_t             state;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [ADDR_W-1:0]  addr;
    logic               phase;
    logic [7:0]         hi_q;
    logic               fmt_q;
    logic               cap_req;

    logic sample, vs_rise, vs_fall, hr_rise, hr_fall;
    logic phase_eff, px_done, px_keep;
    logic [4:0]  r5, b5;
    logic [5:0]  g6;
    logic [23:0] px_rgb;

    // All camera signals share one synchronizer chain so they stay aligned.
    assign cam = sync_q[SYNC_STAGES-1];

    // Synchronize the camera bus and keep one cycle of history for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q  <= '0;
            pclk_d  <= 1'b0;
            vsync_d <= 1'b0;
            href_d  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], i_pclk, i_vsync, i_href, i_data};
            pclk_d  <= cam.pclk;
            vsync_d <= cam.vsync;
            href_d  <= cam.href;
        end
    end

    assign sample  = cam.pclk & ~pclk_d;
    assign vs_rise = cam.vsync & ~vsync_d;
    assign vs_fall = ~cam.vsync & vsync_d;
    assign hr_rise = cam.href & ~href_d;
    assign hr_fall = ~cam.href & href_d;

    // A line start forces the byte phase back to the high byte, even if a
    // sample lands in the same cycle.
    assign phase_eff = hr_rise ? 1'b0 : phase;
    assign px_done   = (state == ACTIVE) && i_enable && sample && cam.href && phase_eff;
    assign px_keep   = px_done
                     && (col < COL_W'(H_ACTIVE)) && (row < ROW_W'(V_ACTIVE))
                     && ((col & COL_W'(DMASK)) == '0) && ((row & ROW_W'(DMASK)) == '0);

    // Bit-replicating expansion to 8 bits per channel.
    assign r5 = hi_q[7:3];
    assign g6 = {hi_q[2:0], cam.data[7:5]};
    assign b5 = cam.data[4:0];
    assign px_rgb = fmt_q ? {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]}
                          : {hi_q[3:0], hi_q[3:0], cam.data[7:4], cam.data[7:4],
                             cam.data[3:0], cam.data[3:0]};

    // Frame/line sequencing, registered pixel write port and status flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            addr         <= '0;
            phase        <= 1'b0;
            hi_q         <= '0;
            fmt_q        <= 1'b0;
            cap_req      <= 1'b0;
            o_wr_valid   <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_frame_done <= 1'b0;
            o_frozen     <= 1'b0;
            o_overflow   <= 1'b0;
            o_err_size   <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            // In FROZEN a capture only counts when it rides along with a release.
            if (i_capture && (state != FROZEN || i_release))
                cap_req <= 1'b1;
            if (!i_enable) begin
                state      <= IDLE;
                o_wr_valid <= 1'b0;
                o_frozen   <= 1'b0;
            end else begin
                if (o_wr_valid && i_wr_ready)
                    o_wr_valid <= 1'b0;
                case (state)
                    IDLE: state <= WAIT_VS;
                    WAIT_VS: if (vs_rise) state <= WAIT_FRAME;
                    WAIT_FRAME: if (vs_fall) begin
                        col   <= '0;
                        row   <= '0;
                        addr  <= '0;
                        phase <= 1'b0;
                        fmt_q <= i_fmt;
                        state <= ACTIVE;
                    end
                    ACTIVE: begin
                        if (hr_rise)
                            phase <= 1'b0;
                        if (sample && cam.href) begin
                            phase <= ~phase_eff;
                            if (!phase_eff)
                                hi_q <= cam.data;
                            else if (col <= COL_W'(H_ACTIVE))
                                col <= col + 1'b1;
                        end
                        // Address tracks raster position, so it advances even
                        // when the pixel itself is dropped.
                        if (px_keep) begin
                            addr <= addr + 1'b1;
                            if (!o_wr_valid || i_wr_ready) begin
                                o_wr_valid <= 1'b1;
                                o_wr_addr  <= addr;
                                o_wr_data  <= px_rgb;
                            end else begin
                                o_overflow <= 1'b1;
                            end
                        end
                        if (hr_fall) begin
                            if (col != COL_W'(H_ACTIVE))
                                o_err_size <= 1'b1;
                            if (row <= ROW_W'(V_ACTIVE))
                                row <= row + 1'b1;
                            col <= '0;
                        end
                        if (vs_rise) begin
                            o_frame_done <= 1'b1;
                            if (row != ROW_W'(V_ACTIVE))
                                o_err_size <= 1'b1;
                            if (cap_req || i_capture) begin
                                cap_req  <= 1'b0;
                                o_frozen <= 1'b1;
                                state    <= FROZEN;
                            end else begin
                                state <= WAIT_FRAME;
                            end
                        end
                    end
                    FROZEN: if (i_release) begin
                        o_frozen <= 1'b0;
                        state    <= WAIT_VS;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_camera_frame_capture.sv
// Bench for camera_frame_capture: two instances (DECIM=1 and DECIM=2) share one
// camera stream; a pixel-level model predicts each instance's write sequence.
`timescale 1ns/1ps
module tb_camera_frame_capture;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int AW = 5;
    localparam int ND = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [23:0]   data;
    } wr_t;

    logic i_clk, i_rst_n, i_enable, i_fmt, i_pclk, i_vsync, i_href;
    logic [7:0] i_data;
    logic i_capture, i_release, i_wr_ready;
    logic          wr_valid   [ND];
    logic [AW-1:0] wr_addr    [ND];
    logic [23:0]   wr_data    [ND];
    logic          frame_done [ND];
    logic          frozen     [ND];
    logic          overflow   [ND];
    logic          err_size   [ND];

    int total = 0;
    int bad   = 0;

    // model state
    wr_t  expq0[$];
    wr_t  expq1[$];
    bit   cap_on = 0;
    bit   fmt_cur = 0;
    int   m_row = 0;
    int   m_addr[ND];
    bit   held[ND];
    int   ready_mode = 1;   // 0 = held low, 1 = high, 2 = random with short low runs
    int   exp_fd = 0;
    int   fd_cnt[ND];
    logic [7:0] fix_hi, fix_lo;

    // monitor state
    bit            p_vld[ND];
    logic [AW-1:0] p_addr[ND];
    logic [23:0]   p_data[ND];
    bit            p_rdy = 0, p_en = 0;
    wr_t           mw;
    int            qs;

    camera_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(1), .ADDR_W(AW), .SYNC_STAGES(2)) u_dut0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_fmt(i_fmt),
        .i_pclk(i_pclk), .i_vsync(i_vsync), .i_href(i_href), .i_data(i_data),
        .i_capture(i_capture), .i_release(i_release),
        .o_wr_valid(wr_valid[0]), .o_wr_addr(wr_addr[0]), .o_wr_data(wr_data[0]),
        .i_wr_ready(i_wr_ready), .o_frame_done(frame_done[0]), .o_frozen(frozen[0]),
        .o_overflow(overflow[0]), .o_err_size(err_size[0]));

    camera_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(2), .ADDR_W(AW), .SYNC_STAGES(2)) u_dut1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_fmt(i_fmt),
        .i_pclk(i_pclk), .i_vsync(i_vsync), .i_href(i_href), .i_data(i_data),
        .i_capture(i_capture), .i_release(i_release),
        .o_wr_valid(wr_valid[1]), .o_wr_addr(wr_addr[1]), .o_wr_data(wr_data[1]),
        .i_wr_ready(i_wr_ready), .o_frame_done(frame_done[1]), .o_frozen(frozen[1]),
        .o_overflow(overflow[1]), .o_err_size(err_size[1]));

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int dec(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    // Channel expansion from the format rules, by arithmetic.
    function automatic logic [23:0] expand(input bit fmt, input logic [7:0] hi, input logic [7:0] lo);
        int h, l, r, g, b;
        h = int'(hi);
        l = int'(lo);
        if (fmt) begin
            r = h / 8;
            g = (h % 8) * 8 + l / 32;
            b = l % 32;
            r = r * 8 + r / 4;
            g = g * 4 + g / 16;
            b = b * 8 + b / 4;
        end else begin
            r = (h % 16) * 17;
            g = (l / 16) * 17;
            b = (l % 16) * 17;
        end
        return 24'(r * 65536 + g * 256 + b);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic cam_clk(input logic href, input logic [7:0] d);
        i_pclk = 1'b0; i_href = href; i_data = d;
        tick(2);
        i_pclk = 1'b1;
        tick(2);
    endtask

    // Expected writes for one camera pixel at (m_row, c) in each instance.
    task automatic model_pixel(input int c, input logic [7:0] hi, input logic [7:0] lo);
        wr_t w;
        for (int d = 0; d < ND; d++) begin
            if (cap_on && c < H && m_row < V && c % dec(d) == 0 && m_row % dec(d) == 0) begin
                if (!(ready_mode == 0 && held[d])) begin
                    w.addr = AW'(m_addr[d]);
                    w.data = expand(fmt_cur, hi, lo);
                    if (d == 0) expq0.push_back(w); else expq1.push_back(w);
                    if (ready_mode == 0) held[d] = 1'b1;
                end
                m_addr[d]++;
            end
        end
    endtask

    task automatic send_px(input int c0, input int n, input bit rnd);
        logic [7:0] hi, lo;
        for (int c = c0; c < c0 + n; c++) begin
            hi = rnd ? 8'($urandom) : fix_hi;
            lo = rnd ? 8'($urandom) : fix_lo;
            model_pixel(c, hi, lo);
            cam_clk(1'b1, hi);
            cam_clk(1'b1, lo);
        end
    endtask

    task automatic end_line();
        cam_clk(1'b0, 8'h00);
        cam_clk(1'b0, 8'h00);
        m_row++;
    endtask

    task automatic send_line(input int n, input bit rnd);
        send_px(0, n, rnd);
        end_line();
    endtask

    task automatic send_frame(input int nlines, input bit rnd);
        for (int r = 0; r < nlines; r++) send_line(H, rnd);
    endtask

    task automatic vs_pulse(input bit fmt);
        cam_clk(1'b0, 8'h00);
        i_vsync = 1'b1;
        cam_clk(1'b0, 8'h00);
        cam_clk(1'b0, 8'h00);
        i_fmt   = fmt;
        i_vsync = 1'b0;
        cam_clk(1'b0, 8'h00);
        cam_clk(1'b0, 8'h00);
        m_row = 0;
        m_addr = '{0, 0};
        fmt_cur = fmt;
    endtask

    task automatic checkpoint(input string tag);
        tick(10);
        chk({tag, "_q0"}, 32'(expq0.size()), 0);
        chk({tag, "_q1"}, 32'(expq1.size()), 0);
        for (int d = 0; d < ND; d++) chk($sformatf("%s_fd%0d", tag, d), 32'(fd_cnt[d]), 32'(exp_fd));
    endtask

    // Ready driver
    initial begin
        int low;
        low = 0;
        i_wr_ready = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            if (ready_mode == 0) i_wr_ready = 1'b0;
            else if (ready_mode == 1) i_wr_ready = 1'b1;
            else if (low >= 3 || $urandom_range(1, 0) == 1) begin
                i_wr_ready = 1'b1; low = 0;
            end else begin
                i_wr_ready = 1'b0; low++;
            end
        end
    end

    // Write/handshake monitor
    always @(negedge i_clk) begin
        for (int d = 0; d < ND; d++) begin
            if (frame_done[d]) fd_cnt[d]++;
            if (p_vld[d] && !p_rdy && p_en && i_enable) begin
                chk($sformatf("d%0d_hold_vld", d), 32'(wr_valid[d]), 1);
                chk($sformatf("d%0d_hold_addr", d), 32'(wr_addr[d]), 32'(p_addr[d]));
                chk($sformatf("d%0d_hold_data", d), 32'(wr_data[d]), 32'(p_data[d]));
            end
            if (wr_valid[d] && i_wr_ready) begin
                qs = (d == 0) ? expq0.size() : expq1.size();
                chk($sformatf("d%0d_wr_expected", d), 32'(qs != 0), 1);
                if (qs != 0) begin
                    mw = (d == 0) ? expq0.pop_front() : expq1.pop_front();
                    chk($sformatf("d%0d_addr", d), 32'(wr_addr[d]), 32'(mw.addr));
                    chk($sformatf("d%0d_data", d), 32'(wr_data[d]), 32'(mw.data));
                end
            end
            p_vld[d]  = wr_valid[d];
            p_addr[d] = wr_addr[d];
            p_data[d] = wr_data[d];
        end
        p_rdy = i_wr_ready;
        p_en  = i_enable;
    end

    initial begin
        i_rst_n = 1'b1; i_enable = 1'b0; i_fmt = 1'b0; i_pclk = 1'b0; i_vsync = 1'b0;
        i_href = 1'b0; i_data = 8'h00; i_capture = 1'b0; i_release = 1'b0;
        fd_cnt = '{0, 0}; m_addr = '{0, 0}; held = '{0, 0};
        #3 i_rst_n = 1'b0;
        tick(3);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("rst_vld%0d", d), 32'(wr_valid[d]), 0);
            chk($sformatf("rst_addr%0d", d), 32'(wr_addr[d]), 0);
            chk($sformatf("rst_data%0d", d), 32'(wr_data[d]), 0);
            chk($sformatf("rst_fd%0d", d), 32'(frame_done[d]), 0);
            chk($sformatf("rst_frz%0d", d), 32'(frozen[d]), 0);
            chk($sformatf("rst_ovf%0d", d), 32'(overflow[d]), 0);
            chk($sformatf("rst_err%0d", d), 32'(err_size[d]), 0);
        end
        i_rst_n = 1'b1;
        tick(2);
        i_enable = 1'b1;
        tick(2);

        // RGB565 fixed colour, ready always high
        cap_on = 1; fix_hi = 8'hF8; fix_lo = 8'h1F;
        vs_pulse(1'b1);
        send_frame(V, 1'b0);
        // RGB444 fixed colour, random ready
        vs_pulse(1'b0); exp_fd++;
        ready_mode = 2; fix_hi = 8'h0A; fix_lo = 8'h5C;
        send_frame(V, 1'b0);
        // random format and data
        repeat (2) begin
            vs_pulse(1'($urandom_range(1, 0))); exp_fd++;
            send_frame(V, 1'b1);
        end
        vs_pulse(1'($urandom_range(1, 0))); exp_fd++;
        checkpoint("rand");

        // capture mid-frame: this frame completes, then freeze
        send_line(H, 1'b1); send_line(H, 1'b1);
        i_capture = 1'b1; tick(1); i_capture = 1'b0;
        send_line(H, 1'b1); send_line(H, 1'b1);
        vs_pulse(1'b0); exp_fd++;
        cap_on = 0;
        for (int d = 0; d < ND; d++) chk($sformatf("frozen%0d", d), 32'(frozen[d]), 1);
        repeat (2) begin
            send_frame(V, 1'b1);
            vs_pulse(1'b1);
        end
        send_line(H, 1'b1); send_line(H, 1'b1);
        for (int d = 0; d < ND; d++) chk($sformatf("still_frozen%0d", d), 32'(frozen[d]), 1);
        checkpoint("frz");
        i_release = 1'b1; tick(1); i_release = 1'b0;
        for (int d = 0; d < ND; d++) chk($sformatf("released%0d", d), 32'(frozen[d]), 0);
        send_line(H, 1'b1); send_line(H, 1'b1);
        vs_pulse(1'b1);
        cap_on = 1;
        send_frame(V, 1'b1);
        vs_pulse(1'b0); exp_fd++;
        checkpoint("rel");

        // enable dropped while a pixel is held
        ready_mode = 0; tick(2);
        send_px(0, 1, 1'b1);
        tick(2);
        for (int d = 0; d < ND; d++) chk($sformatf("en_vld%0d", d), 32'(wr_valid[d]), 1);
        i_enable = 1'b0;
        tick(1);
        for (int d = 0; d < ND; d++) chk($sformatf("dis_vld%0d", d), 32'(wr_valid[d]), 0);
        chk("dis_q0", 32'(expq0.size()), 1);
        chk("dis_q1", 32'(expq1.size()), 1);
        void'(expq0.pop_front()); void'(expq1.pop_front());
        held = '{0, 0}; ready_mode = 1; cap_on = 0;
        tick(2);
        i_enable = 1'b1;
        send_px(1, H - 1, 1'b1); end_line();
        send_frame(V - 1, 1'b1);
        vs_pulse(1'b1);
        cap_on = 1;
        send_frame(V, 1'b1);
        vs_pulse(1'b0); exp_fd++;
        checkpoint("ena");

        // backpressure across three pixels
        ready_mode = 0; tick(2);
        send_px(0, 3, 1'b1);
        tick(1);
        ready_mode = 1; held = '{0, 0};
        send_px(3, H - 3, 1'b1); end_line();
        send_frame(V - 1, 1'b1);
        for (int d = 0; d < ND; d++) chk($sformatf("ovf%0d", d), 32'(overflow[d]), 1);
        for (int d = 0; d < ND; d++) chk($sformatf("err_pre%0d", d), 32'(err_size[d]), 0);
        vs_pulse(1'b1); exp_fd++;
        checkpoint("ovf");

        // short frame: three lines
        send_frame(V - 1, 1'b1);
        for (int d = 0; d < ND; d++) chk($sformatf("err_3l_pre%0d", d), 32'(err_size[d]), 0);
        vs_pulse(1'b0); exp_fd++;
        for (int d = 0; d < ND; d++) chk($sformatf("err_3l%0d", d), 32'(err_size[d]), 1);
        // short line: addresses continue without gaps
        send_line(H - 1, 1'b1);
        send_frame(V - 1, 1'b1);
        vs_pulse(1'b1); exp_fd++;
        checkpoint("err");
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("ovf_sticky%0d", d), 32'(overflow[d]), 1);
            chk($sformatf("err_sticky%0d", d), 32'(err_size[d]), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/camera_frame_capture.md
Name: camera_frame_capture

Overview:
Parametrised OV7670 pixel-capture engine. It samples the camera's parallel bus synchronously in the system clock domain and assembles RGB444 or RGB565 byte pairs into RGB888 pixels. Pixels are optionally decimated and emitted as addressed writes to the frame-buffer/SDRAM writer. It supports a NIOS-driven freeze/release handshake for still capture, and sits between the camera initializer and the SDRAM/VGA path.

Parameters:
H_ACTIVE, 640, active pixels per line (camera pixels, before decimation)
V_ACTIVE, 480, active lines per frame
DECIM, 1, decimation factor in both axes; legal values 1, 2, 4
ADDR_W, 19, write address width; must hold (H_ACTIVE/DECIM)*(V_ACTIVE/DECIM)
SYNC_STAGES, 2, synchronizer depth for the camera inputs (≥2)

Ports:
i_clk  in  1  system clock; must be ≥3× camera pclk
i_rst_n  in  1  asynchronous active-low reset
i_enable  in  1  initializer finished; low forces IDLE
i_fmt  in  1  0 = RGB444 (xR GB), 1 = RGB565; sampled only at frame start
i_pclk  in  1  camera pixel clock (treated as data)
i_vsync  in  1  camera vsync, active high between frames
i_href  in  1  camera line valid
i_data  in  8  camera data byte
i_capture  in  1  one-cycle request: freeze after the current frame completes
i_release  in  1  one-cycle: leave FROZEN
o_wr_valid  out  1  pixel write valid
o_wr_addr  out  ADDR_W  pixel address, linear raster of the decimated frame
o_wr_data  out  24  {R8,G8,B8}
i_wr_ready  in  1  writer accepts when valid&ready
o_frame_done  out  1  one-cycle pulse at frame end
o_frozen  out  1  high in FROZEN
o_overflow  out  1  sticky: pixel dropped due to backpressure
o_err_size  out  1  sticky: line or frame length ≠ H_ACTIVE/V_ACTIVE

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, capture request cleared, sticky flags cleared. Stickies clear only on reset.
- Input path: i_pclk, i_vsync, i_href and i_data each pass through SYNC_STAGES flops. A sample event is a rising edge of the synced pclk (synced-current=1, previous=0). href, vsync and data are taken from the same synced stage.
- States:
  - IDLE: waits for i_enable=1, then goes to WAIT_VS.
  - WAIT_VS: on synced vsync rising, goes to WAIT_FRAME.
  - WAIT_FRAME: on vsync falling, clears row/col/addr/byte-phase, latches i_fmt, then goes to ACTIVE.
  - ACTIVE: handles lines and pixels (below). On vsync rising, pulses o_frame_done for 1 cycle. Sets o_err_size if row≠V_ACTIVE. Then goes to FROZEN if a capture request is pending (request cleared), else to WAIT_FRAME.
  - FROZEN: o_frozen=1, no writes. On i_release, goes to WAIT_VS, so restart always begins on a full frame.
  - Any state: i_enable=0 → IDLE next cycle; o_wr_valid dropped, pending pixel discarded, capture request kept.
- Line handling:
  - Byte phase resets to 0 at each href rising.
  - Each sample event with href=1 toggles the phase. Phase 0 stores byte hi; phase 1 completes a pixel with byte lo.
  - At href falling: if col≠H_ACTIVE, set o_err_size; row++, col=0.
  - Pixels with col≥H_ACTIVE or row≥V_ACTIVE are discarded.
- Format expansion (bit replication):
  - RGB444: R4=hi[3:0], G4=lo[7:4], B4=lo[3:0]; each 4-bit x → {x,x}.
  - RGB565: R5=hi[7:3], G6={hi[2:0],lo[7:5]}, B5=lo[4:0]; 5-bit x → {x,x[4:2]}, 6-bit x → {x,x[5:4]}.
- Decimation: a pixel is kept iff col%DECIM==0 and row%DECIM==0. The address comes from an incrementing counter (no multiplier), advanced once per kept pixel and reset to 0 at frame start. The last address is (H_ACTIVE/DECIM)*(V_ACTIVE/DECIM)−1.
- Write handshake:
  - o_wr_valid/addr/data are registered and go valid 1 i_clk after the phase-1 sample event.
  - They are held stable until i_wr_ready=1; valid drops the cycle after acceptance unless a new pixel completes that same cycle, in which case the new pixel loads.
  - A pixel completing while valid&!ready is dropped and sets o_overflow; the held pixel is unaffected.
- Capture: i_capture in any state sets the pending request. If it arrives in the same cycle as the vsync rising in ACTIVE, the current frame freezes. Repeated i_capture while pending has no extra effect. i_capture in FROZEN is ignored.
- Simultaneous events: i_release and i_capture in the same FROZEN cycle → release wins and the request stays pending (freezes after the next frame).

Test Plan:
- RGB565 frame, H=8, V=4, DECIM=1, ready=1, hi=0xF8 lo=0x1F → 32 writes, addr 0..31, data 0xFF00FF; one o_frame_done; o_err_size=0.
- RGB444, DECIM=2, H=8, V=4, pixel hi=0x0A lo=0x5C → 8 writes, addr 0..7, only even col/row, data 0xAA55CC.
- Hold i_wr_ready=0 across 3 pixels → first pixel held stable, 2 drops, o_overflow=1 and stays 1 after ready returns.
- Line with 7 pixels (H=8), then frame with 3 lines (V=4) → o_err_size=1; addresses continue from the counter without gaps.
- i_capture mid-frame → frame completes, o_frame_done pulse, o_frozen=1, no writes through the next 2 frames; i_release mid-frame → no writes until the next vsync falling, then addr restarts at 0.
- i_enable dropped mid-line with o_wr_valid=1 → o_wr_valid=0 next cycle, state IDLE; re-enable → capture resumes only from a full frame.
